// File: rtl/eth_rx_framer.sv
// GMII receive framer: preamble/SFD strip, FCS and length check,
// optional FCS removal, beat packing and good/bad frame counters.
module eth_rx_framer #(
  parameter int OUT_BYTES = 1,
  parameter int STRIP_FCS = 1,
  parameter int MIN_LEN   = 64,
  parameter int MAX_LEN   = 1518,
  parameter int CNT_W     = 32
) (
  input  logic                   rxClkIn,
  input  logic                   rstIn,
  input  logic [7:0]             gmiiDataIn,
  input  logic                   gmiiDvIn,
  input  logic                   gmiiErIn,
  output logic [8*OUT_BYTES-1:0] rxDataOut,
  output logic [OUT_BYTES-1:0]   rxKeepOut,
  output logic                   rxDataValidOut,
  output logic                   rxDataLastOut,
  output logic [2:0]             rxErrOut,
  output logic [CNT_W-1:0]       frameCntOut,
  output logic [CNT_W-1:0]       errCntOut
);

  localparam int         HOLD      = (STRIP_FCS != 0) ? 5 : 1;
  localparam logic [2:0] HOLD_N    = 3'(HOLD);
  localparam logic [3:0] LAST_LANE = 4'(OUT_BYTES - 1);
  localparam logic [15:0] MIN_L    = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L    = 16'(MAX_LEN);
  localparam logic [31:0] RESIDUE  = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    DROP
  } state_e;

  state_e state_q, state_d;
  logic        armed_q, armed_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] len_q, len_d;
  logic        er_q, er_d;
  logic [7:0]  hold_q [HOLD];
  logic [7:0]  hold_d [HOLD];
  logic [2:0]  hcnt_q, hcnt_d;

  logic [8*OUT_BYTES-1:0] acc_q, acc_d;
  logic [3:0]             fill_q, fill_d;

  logic [8*OUT_BYTES-1:0] data_q, data_d;
  logic [OUT_BYTES-1:0]   keep_q, keep_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic [2:0]             err_q, err_d;
  logic [CNT_W-1:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0]       ecnt_q, ecnt_d;

  logic       rel_v;
  logic       rel_last;
  logic       runt;
  logic [7:0] rel_byte;
  logic [2:0] frame_err;

  function automatic logic [31:0] crc_upd(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320)
                        : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q | ~gmiiDvIn;
    crc_d     = crc_q;
    len_d     = len_q;
    er_d      = er_q;
    hold_d    = hold_q;
    hcnt_d    = hcnt_q;
    rel_v     = 1'b0;
    rel_last  = 1'b0;
    runt      = 1'b0;
    rel_byte  = hold_q[0];
    frame_err = {er_q,
                 (len_q < MIN_L) || (len_q > MAX_L),
                 crc_q != RESIDUE};

    unique case (state_q)
      IDLE: begin
        if (armed_q && gmiiDvIn) begin
          state_d = (gmiiDataIn == 8'h55) ? PRE : DROP;
        end
      end
      PRE: begin
        if (!gmiiDvIn) begin
          state_d = IDLE;
        end else if (gmiiDataIn == 8'h55) begin
          state_d = PRE;
        end else if (gmiiDataIn == 8'hD5) begin
          state_d = DATA;
          crc_d   = 32'hFFFFFFFF;
          len_d   = '0;
          er_d    = 1'b0;
          hcnt_d  = '0;
        end else begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (gmiiDvIn) begin
          crc_d = crc_upd(crc_q, gmiiDataIn);
          if (len_q != 16'hFFFF) len_d = len_q + 16'd1;
          if (gmiiErIn) er_d = 1'b1;
          // full hold line: oldest byte leaves as the new one enters
          if (hcnt_q == HOLD_N) begin
            rel_v = 1'b1;
            for (int i = 0; i < HOLD - 1; i++) begin
              hold_d[i] = hold_q[i+1];
            end
            hold_d[HOLD-1] = gmiiDataIn;
          end else begin
            for (int i = 0; i < HOLD; i++) begin
              if (hcnt_q == 3'(i)) hold_d[i] = gmiiDataIn;
            end
            hcnt_d = hcnt_q + 3'd1;
          end
        end else begin
          state_d = IDLE;
          if (hcnt_q == HOLD_N) begin
            rel_v    = 1'b1;
            rel_last = 1'b1;
          end else begin
            runt = 1'b1;
          end
        end
      end
      DROP: begin
        if (!gmiiDvIn) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    acc_d   = acc_q;
    fill_d  = fill_q;
    data_d  = '0;
    keep_d  = '0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    err_d   = '0;
    fcnt_d  = fcnt_q;
    ecnt_d  = ecnt_q;

    if (rel_v) begin
      for (int l = 0; l < OUT_BYTES; l++) begin
        if (fill_q == 4'(l)) acc_d[8*l +: 8] = rel_byte;
      end
      if (rel_last || fill_q == LAST_LANE) begin
        valid_d = 1'b1;
        last_d  = rel_last;
        data_d  = acc_d;
        for (int l = 0; l < OUT_BYTES; l++) begin
          keep_d[l] = (4'(l) <= fill_q);
        end
        acc_d  = '0;
        fill_d = '0;
      end else begin
        fill_d = fill_q + 4'd1;
      end
    end

    if (runt) begin
      valid_d = 1'b1;
      last_d  = 1'b1;
    end

    if (last_d) begin
      err_d = frame_err;
      if (frame_err == 3'b000) fcnt_d = fcnt_q + 1'b1;
      else                     ecnt_d = ecnt_q + 1'b1;
    end
  end

  always_ff @(posedge rxClkIn or posedge rstIn) begin
    if (rstIn) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      crc_q   <= '0;
      len_q   <= '0;
      er_q    <= 1'b0;
      for (int i = 0; i < HOLD; i++) hold_q[i] <= '0;
      hcnt_q  <= '0;
      acc_q   <= '0;
      fill_q  <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= '0;
      fcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      crc_q   <= crc_d;
      len_q   <= len_d;
      er_q    <= er_d;
      hold_q  <= hold_d;
      hcnt_q  <= hcnt_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign rxDataOut      = data_q;
  assign rxKeepOut      = keep_q;
  assign rxDataValidOut = valid_q;
  assign rxDataLastOut  = last_q;
  assign rxErrOut       = err_q;
  assign frameCntOut    = fcnt_q;
  assign errCntOut      = ecnt_q;

endmodule
